baccarat_round_ctrl: RTL and testbench

BACCARAT_ROUND_CTRL -- requirements
Module: baccarat_round_ctrl

---
 rtl/baccarat_round_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_baccarat_round_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/baccarat_round_ctrl.sv
// Round sequencer for a punto-banco baccarat table: deals the four opening
// cards, applies the player and banker third-card rules from the datapath
// hand totals, then registers the round result and keeps win/tie tallies.
module baccarat_round_ctrl (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       start,
    input  logic       card_valid,
    input  logic [3:0] card,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    output logic       card_req,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       busy,
    output logic [7:0] player_wins,
    output logic [7:0] dealer_wins,
    output logic [7:0] ties,
    output logic [3:0] pcard3_val
);

    localparam int unsigned CARD_W  = 4;
    localparam int unsigned TALLY_W = 8;
    localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_P1     = 4'd1,
        S_D1     = 4'd2,
        S_P2     = 4'd3,
        S_D2     = 4'd4,
        S_EVAL   = 4'd5,
        S_P3     = 4'd6,
        S_EVAL3  = 4'd7,
        S_D3     = 4'd8,
        S_RESULT = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CARD_W-1:0]    w_card_val;
    logic                 w_d3_draw;
    logic                 w_round_start;
    logic                 r_player_light;
    logic                 r_dealer_light;
    logic [TALLY_W-1:0]   r_player_wins;
    logic [TALLY_W-1:0]   r_dealer_wins;
    logic [TALLY_W-1:0]   r_ties;
    logic [CARD_W-1:0]    r_pcard3_val;

    // Baccarat value of the presented card: tens, faces and illegal codes are 0
    assign w_card_val = (card >= CARD_W'(1) && card <= CARD_W'(9)) ? card : '0;

    // A new round may only be launched from an idle or finished table
    assign w_round_start = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

    // Banker third-card tableau once the player has drawn
    always_comb begin
        w_d3_draw = 1'b0;
        case (dscore)
            4'd0, 4'd1, 4'd2: w_d3_draw = 1'b1;
            4'd3:             w_d3_draw = (r_pcard3_val != CARD_W'(8));
            4'd4:             w_d3_draw = (r_pcard3_val >= CARD_W'(2)) && (r_pcard3_val <= CARD_W'(7));
            4'd5:             w_d3_draw = (r_pcard3_val >= CARD_W'(4)) && (r_pcard3_val <= CARD_W'(7));
            4'd6:             w_d3_draw = (r_pcard3_val >= CARD_W'(6)) && (r_pcard3_val <= CARD_W'(7));
            default:          w_d3_draw = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode, card request and same-cycle load strobes
    always_comb begin
        w_next      = r_state;
        card_req    = 1'b0;
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE, S_DONE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_P1;
                end
            end
            S_P1: begin
                card_req    = 1'b1;
                load_pcard1 = card_valid;
                if (card_valid) begin
                    w_next = S_D1;
                end
            end
            S_D1: begin
                card_req    = 1'b1;
                load_dcard1 = card_valid;
                if (card_valid) begin
                    w_next = S_P2;
                end
            end
            S_P2: begin
                card_req    = 1'b1;
                load_pcard2 = card_valid;
                if (card_valid) begin
                    w_next = S_D2;
                end
            end
            S_D2: begin
                card_req    = 1'b1;
                load_dcard2 = card_valid;
                if (card_valid) begin
                    w_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (pscore >= CARD_W'(8) || dscore >= CARD_W'(8)) begin
                    w_next = S_RESULT;
                end else if (pscore <= CARD_W'(5)) begin
                    w_next = S_P3;
                end else if (dscore <= CARD_W'(5)) begin
                    w_next = S_D3;
                end else begin
                    w_next = S_RESULT;
                end
            end
            S_P3: begin
                card_req    = 1'b1;
                load_pcard3 = card_valid;
                if (card_valid) begin
                    w_next = S_EVAL3;
                end
            end
            S_EVAL3: begin
                w_next = w_d3_draw ? S_D3 : S_RESULT;
            end
            S_D3: begin
                card_req    = 1'b1;
                load_dcard3 = card_valid;
                if (card_valid) begin
                    w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Result lights and saturating tallies, cleared when a round is launched
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_player_light <= 1'b0;
            r_dealer_light <= 1'b0;
            r_player_wins  <= '0;
            r_dealer_wins  <= '0;
            r_ties         <= '0;
        end else begin
            if (w_round_start) begin
                r_player_light <= 1'b0;
                r_dealer_light <= 1'b0;
            end
            if (r_state == S_RESULT) begin
                if (pscore > dscore) begin
                    r_player_light <= 1'b1;
                    r_dealer_light <= 1'b0;
                    if (r_player_wins != TALLY_MAX) begin
                        r_player_wins <= r_player_wins + TALLY_W'(1);
                    end
                end else if (pscore < dscore) begin
                    r_player_light <= 1'b0;
                    r_dealer_light <= 1'b1;
                    if (r_dealer_wins != TALLY_MAX) begin
                        r_dealer_wins <= r_dealer_wins + TALLY_W'(1);
                    end
                end else begin
                    r_player_light <= 1'b1;
                    r_dealer_light <= 1'b1;
                    if (r_ties != TALLY_MAX) begin
                        r_ties <= r_ties + TALLY_W'(1);
                    end
                end
            end
        end
    end

    // Player third-card value, kept for the banker decision in EVAL3
    always_ff @(posedge slow_clock) begin
        if (resetb) begin
            r_pcard3_val <= '0;
        end else if (load_pcard3) begin
            r_pcard3_val <= w_card_val;
        end
    end

    assign player_win_light = r_player_light;
    assign dealer_win_light = r_dealer_light;
    assign player_wins      = r_player_wins;
    assign dealer_wins      = r_dealer_wins;
    assign ties             = r_ties;
    assign pcard3_val       = r_pcard3_val;

endmodule

// File: tb/tb_baccarat_round_ctrl.sv
// Bench for baccarat_round_ctrl: emulates the card-register datapath, runs a
// table of hand-derived rounds, corner sequences and random rounds scored by
// a rules-level baccarat model.
module tb_baccarat_round_ctrl;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b1;
    logic       start      = 1'b0;
    logic       card_valid = 1'b0;
    logic [3:0] card       = 4'd0;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       card_req;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light, busy;
    logic [7:0] player_wins, dealer_wins, ties;
    logic [3:0] pcard3_val;

    typedef logic [5:0][3:0] hand_t;
    typedef struct {
        hand_t c;
        int    seq;
        int    win;
        int    p3;
        int    lat;
    } vec_t;

    vec_t vt [10];
    int   errors = 0;
    int   checks = 0;
    int   exp_pw = 0;
    int   exp_dw = 0;
    int   exp_t  = 0;
    int   exp_p3 = 0;

    baccarat_round_ctrl dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .start            (start),
        .card_valid       (card_valid),
        .card             (card),
        .pscore           (pscore),
        .dscore           (dscore),
        .card_req         (card_req),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .busy             (busy),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins),
        .ties             (ties),
        .pcard3_val       (pcard3_val)
    );

    always #5 slow_clock = ~slow_clock;

    wire [5:0] w_strobes = {load_dcard3, load_pcard3, load_dcard2,
                            load_pcard2, load_dcard1, load_pcard1};

    function automatic int bval(input logic [3:0] c);
        return (c >= 4'd1 && c <= 4'd9) ? int'(c) : 0;
    endfunction

    // Datapath stand-in: card registers and hand totals valid a cycle after a strobe
    logic [3:0] dp_p0 = 4'd0, dp_p1 = 4'd0, dp_p2 = 4'd0;
    logic [3:0] dp_d0 = 4'd0, dp_d1 = 4'd0, dp_d2 = 4'd0;
    always @(posedge slow_clock) begin
        if (load_pcard1) begin dp_p0 <= card; dp_p1 <= 4'd0; dp_p2 <= 4'd0; end
        if (load_pcard2) dp_p1 <= card;
        if (load_pcard3) dp_p2 <= card;
        if (load_dcard1) begin dp_d0 <= card; dp_d1 <= 4'd0; dp_d2 <= 4'd0; end
        if (load_dcard2) dp_d1 <= card;
        if (load_dcard3) dp_d2 <= card;
    end
    assign pscore = 4'((bval(dp_p0) + bval(dp_p1) + bval(dp_p2)) % 10);
    assign dscore = 4'((bval(dp_d0) + bval(dp_d1) + bval(dp_d2)) % 10);

    // Strobe log: id 1..6 = P1,D1,P2,D2,P3,D3; multi_cnt counts cycles with >1 strobe
    int slog [$];
    int multi_cnt = 0;
    always @(posedge slow_clock) begin
        if ($countones(w_strobes) > 1) multi_cnt++;
        for (int i = 0; i < 6; i++) begin
            if (w_strobes[i]) slog.push_back(i + 1);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic hand_t hand(input int a, input int b, input int c, input int d,
                                   input int e, input int f);
        hand_t h;
        h[0] = 4'(a); h[1] = 4'(b); h[2] = 4'(c);
        h[3] = 4'(d); h[4] = 4'(e); h[5] = 4'(f);
        return h;
    endfunction

    function automatic bit banker_draws(input int ds, input int t);
        case (ds)
            0, 1, 2: return 1'b1;
            3:       return (t != 8);
            4:       return (t >= 2 && t <= 7);
            5:       return (t >= 4 && t <= 7);
            6:       return (t >= 6 && t <= 7);
            default: return 1'b0;
        endcase
    endfunction

    // Rules-level reference: deal order, draws, winner (0 player, 1 banker, 2 tie)
    function automatic void ref_round(input hand_t c, output int seq, output int win, output int p3);
        int  ps, ds, k;
        bit  ddraw;
        ps  = (bval(c[0]) + bval(c[2])) % 10;
        ds  = (bval(c[1]) + bval(c[3])) % 10;
        seq = 1234;
        p3  = -1;
        k   = 4;
        if (ps < 8 && ds < 8) begin
            if (ps <= 5) begin
                p3    = bval(c[4]);
                ps    = (ps + p3) % 10;
                seq   = seq * 10 + 5;
                k     = 5;
                ddraw = banker_draws(ds, p3);
            end else begin
                ddraw = (ds <= 5);
            end
            if (ddraw) begin
                ds  = (ds + bval(c[k])) % 10;
                seq = seq * 10 + 6;
            end
        end
        win = (ps > ds) ? 0 : ((ps < ds) ? 1 : 2);
    endfunction

    task automatic do_reset();
        @(negedge slow_clock);
        resetb = 1'b1; start = 1'b0; card_valid = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        resetb = 1'b0;
        exp_pw = 0; exp_dw = 0; exp_t = 0; exp_p3 = 0;
    endtask

    task automatic check_idle_clear(input string tag);
        card_valid = 1'b1;
        #1;
        check({tag, "_card_req"}, 32'(card_req), 0);
        check({tag, "_strobes"}, 32'(w_strobes), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_lights"}, 32'({player_win_light, dealer_win_light}), 0);
        check({tag, "_tallies"}, 32'({player_wins, dealer_wins, ties}), 0);
        check({tag, "_pcard3_val"}, 32'(pcard3_val), 0);
        card_valid = 1'b0;
    endtask

    // One full round from IDLE/DONE; e_p3 < 0 means the player stands, e_lat < 0 skips latency
    task automatic run_round(input hand_t c, input int vpct, input bit hold,
                             input int e_seq, input int e_win, input int e_p3, input int e_lat);
        int         idx, cyc, base, mb, code;
        logic [1:0] e_lights;
        idx = 0; cyc = 0; code = 0;
        base = slog.size(); mb = multi_cnt;
        @(negedge slow_clock);
        start = 1'b1; card_valid = 1'b0;
        @(negedge slow_clock);
        check("start_clears_lights", 32'({player_win_light, dealer_win_light}), 0);
        check("busy_in_round", 32'(busy), 1);
        if (!hold) start = 1'b0;
        while (cyc < 200) begin
            card_valid = ($urandom_range(99) < 32'(vpct));
            card = (idx < 6) ? c[idx] : 4'd0;
            #1;
            if (!busy) break;
            if (card_req && card_valid) idx++;
            @(negedge slow_clock);
            cyc++;
        end
        start = 1'b0; card_valid = 1'b0;
        check("round_within_budget", 32'(cyc < 200), 1);
        for (int i = base; i < slog.size(); i++) code = code * 10 + slog[i];
        case (e_win)
            0:       begin if (exp_pw < 255) exp_pw++; e_lights = 2'b10; end
            1:       begin if (exp_dw < 255) exp_dw++; e_lights = 2'b01; end
            default: begin if (exp_t  < 255) exp_t++;  e_lights = 2'b11; end
        endcase
        if (e_p3 >= 0) exp_p3 = e_p3;
        check("strobe_sequence", 32'(code), 32'(e_seq));
        check("one_strobe_per_cycle", 32'(multi_cnt - mb), 0);
        check("lights", 32'({player_win_light, dealer_win_light}), 32'(e_lights));
        check("player_wins", 32'(player_wins), 32'(exp_pw));
        check("dealer_wins", 32'(dealer_wins), 32'(exp_dw));
        check("ties", 32'(ties), 32'(exp_t));
        check("pcard3_val", 32'(pcard3_val), 32'(exp_p3));
        if (e_lat >= 0) check("round_latency", 32'(cyc), 32'(e_lat));
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        // Hand-derived rounds: cards in deal order P1,D1,P2,D2,then third cards
        vt[0] = '{c: hand(8, 2, 10, 3, 0, 0),  seq: 1234,   win: 0, p3: -1, lat: 6};
        vt[1] = '{c: hand(3, 4, 3, 3, 0, 0),   seq: 1234,   win: 1, p3: -1, lat: 6};
        vt[2] = '{c: hand(1, 3, 10, 4, 5, 0),  seq: 12345,  win: 1, p3: 5,  lat: 8};
        vt[3] = '{c: hand(2, 3, 3, 3, 12, 0),  seq: 12345,  win: 1, p3: 0,  lat: 8};
        vt[4] = '{c: hand(2, 3, 3, 3, 6, 5),   seq: 123456, win: 2, p3: 6,  lat: 9};
        vt[5] = '{c: hand(3, 2, 3, 2, 9, 0),   seq: 12346,  win: 0, p3: -1, lat: 7};
        vt[6] = '{c: hand(0, 15, 14, 9, 0, 0), seq: 1234,   win: 1, p3: -1, lat: 6};
        vt[7] = '{c: hand(1, 1, 2, 2, 8, 0),   seq: 12345,  win: 1, p3: 8,  lat: 8};
        vt[8] = '{c: hand(1, 1, 1, 1, 8, 4),   seq: 123456, win: 1, p3: 8,  lat: 9};
        vt[9] = '{c: hand(10, 2, 4, 3, 4, 3),  seq: 123456, win: 2, p3: 4,  lat: 9};

        do_reset();
        check_idle_clear("reset");

        // Table rounds with an always-valid card source; round 1 holds start throughout
        for (int i = 0; i < 10; i++) begin
            run_round(vt[i].c, 100, (i == 1), vt[i].seq, vt[i].win, vt[i].p3, vt[i].lat);
        end

        // Stall in D1: no strobe while card_valid is low, then exactly one dcard1 load
        @(negedge slow_clock);
        start = 1'b1; card_valid = 1'b0;
        @(negedge slow_clock);
        start = 1'b0; card = 4'd8; card_valid = 1'b1;
        #1 check("stall_p1_strobe", 32'(w_strobes), 32'(6'b000001));
        @(negedge slow_clock);
        card_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_card_req", 32'(card_req), 1);
            check("stall_no_strobe", 32'(w_strobes), 0);
            @(negedge slow_clock);
        end
        card = 4'd2; card_valid = 1'b1;
        #1 check("stall_release_strobe", 32'(w_strobes), 32'(6'b000010));
        @(negedge slow_clock);
        card_valid = 1'b0;
        #1;
        check("stall_moved_to_p2", 32'({card_req, w_strobes}), 32'(7'b1000000));
        card = 4'd10; card_valid = 1'b1;
        @(negedge slow_clock);
        card = 4'd3;
        @(negedge slow_clock);
        card_valid = 1'b0;
        @(negedge slow_clock);
        @(negedge slow_clock);
        if (exp_pw < 255) exp_pw++;
        check("stall_lights", 32'({player_win_light, dealer_win_light}), 32'(2'b10));
        check("stall_player_wins", 32'(player_wins), 32'(exp_pw));

        // Reset while waiting in P3, with start and a valid card in the same cycle
        @(negedge slow_clock);
        start = 1'b1;
        @(negedge slow_clock);
        start = 1'b0; card = 4'd1; card_valid = 1'b1;
        repeat (4) @(negedge slow_clock);
        card_valid = 1'b0;
        @(negedge slow_clock);
        #1 check("midround_in_p3", 32'(card_req), 1);
        resetb = 1'b1; start = 1'b1; card_valid = 1'b1; card = 4'd5;
        @(negedge slow_clock);
        resetb = 1'b0; start = 1'b0; card_valid = 1'b0;
        exp_pw = 0; exp_dw = 0; exp_t = 0; exp_p3 = 0;
        check_idle_clear("midreset");
        run_round(vt[0].c, 100, 1'b0, vt[0].seq, vt[0].win, vt[0].p3, vt[0].lat);

        // Random rounds with a stalling source, scored by the reference model
        for (int r = 0; r < 40; r++) begin
            hand_t h;
            int    s, w, p;
            for (int k = 0; k < 6; k++) begin
                if ($urandom_range(9) == 0)
                    h[k] = ($urandom_range(2) == 0) ? 4'd0 : 4'(13 + $urandom_range(2, 1));
                else
                    h[k] = 4'($urandom_range(13, 1));
            end
            ref_round(h, s, w, p);
            run_round(h, 40 + int'($urandom_range(60)), 1'($urandom_range(1)), s, w, p, -1);
        end

        // Tally saturation over 256 player naturals
        do_reset();
        for (int r = 0; r < 256; r++) begin
            run_round(vt[0].c, 100, 1'b0, vt[0].seq, vt[0].win, vt[0].p3, vt[0].lat);
        end
        check("player_wins_saturated", 32'(player_wins), 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
